fixed_to_float: RTL and testbench

- Converts a signed two's-complement fixed-point value, e.g. a CORDIC cos/sin result, into IEEE-754 single precision for return to the float domain.
- It is the return-path counterpart of the float-to-fixed input converter.
- Normalisation is iterative, one shift per clock, behind a valid/ready handshake on both sides.

---
 rtl/fixed_to_float.sv | 103 ++++++++++
 tb/tb_fixed_to_float.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_float.sv
// Signed fixed-point to IEEE-754 single converter, iterative normaliser.
// Optional FIXED_TO_FLOAT_SHIFT4_EN: skip four leading zeros per clock.
module fixed_to_float #(
  parameter int INTS = 1,
  parameter int FRACS = 21,
  localparam int WIDTH = 1 + INTS + FRACS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_fixed,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_float,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int MW = INTS + FRACS;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [7:0] EXP0 = 8'(127 + INTS);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } state_t;

  state_t state, stateNext;
  logic [WIDTH-1:0] mag, magNext;
  logic [7:0] expR, expNext;
  logic signR, signNext;
  logic [31:0] floatR, floatNext;
  logic [22:0] frac;

  // mag[MW] is the hidden bit; the rest is left-aligned
  assign frac = 23'(mag[MW-1:0]) << (23 - MW);

  assign in_ready = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_float = floatR;

  always_comb begin
    stateNext = state;
    magNext = mag;
    expNext = expR;
    signNext = signR;
    floatNext = floatR;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          signNext = in_fixed[WIDTH-1];
          magNext = in_fixed[WIDTH-1]
                  ? (~in_fixed + ONE)
                  : in_fixed;
          expNext = EXP0;
          if (magNext == '0) begin
            floatNext = '0;
            stateNext = DONE;
          end else begin
            stateNext = NORM;
          end
        end
      end
      NORM: begin
        if (mag[MW]) begin
          floatNext = {signR, expR, frac};
          stateNext = DONE;
        end
`ifdef FIXED_TO_FLOAT_SHIFT4_EN
        else if (mag[MW -: 4] == 4'd0) begin
          magNext = mag << 4;
          expNext = expR - 8'd4;
        end
`endif
        else begin
          magNext = mag << 1;
          expNext = expR - 8'd1;
        end
      end
      DONE: begin
        if (out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mag <= '0;
      expR <= '0;
      signR <= 1'b0;
      floatR <= '0;
    end else begin
      state <= stateNext;
      mag <= magNext;
      expR <= expNext;
      signR <= signNext;
      floatR <= floatNext;
    end
  end

endmodule

// File: tb/tb_fixed_to_float.sv
// Scoreboard bench for fixed_to_float: random and directed conversions
// checked against a real-arithmetic reference model.
module tb_fixed_to_float;

  localparam int INTS = 1;
  localparam int FRACS = 21;
  localparam int MW = INTS + FRACS;
  localparam int WIDTH = 1 + MW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [WIDTH-1:0] in_fixed = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [31:0] out_float;
  logic out_valid;
  logic out_ready = 1'b1;

  fixed_to_float #(.INTS(INTS), .FRACS(FRACS)) dut (
    .clk(clk),
    .reset(reset),
    .in_fixed(in_fixed),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_float(out_float),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] f;
    int lat;
    int acc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int edgeCnt = 0;
  int readyMode = 1;
  logic prevValid = 1'b0;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  always @(posedge clk) begin
    #2;
    if (readyMode == 2) out_ready = 1'($urandom_range(0, 1));
    else out_ready = readyMode[0];
  end

  function automatic logic [31:0] refFloat(input logic [WIDTH-1:0] x);
    real r;
    logic [63:0] b;
    int e;
    r = $itor($signed(x)) / $itor(1 << FRACS);
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    e = int'(b[62:52]) - 1023 + 127;
    return {b[63], 8'(e), b[51:29]};
  endfunction

  function automatic int refLat(input logic [31:0] f);
    int p;
    int lz;
    if (f == 32'h0) return 0;
    p = int'(f[30:23]) - 127 + FRACS;
    lz = MW - p;
`ifdef FIXED_TO_FLOAT_SHIFT4_EN
    return lz / 4 + lz % 4 + 1;
`else
    return lz + 1;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] v, input bit expectOut);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout got=0 want=1");
    end
    in_fixed = v;
    in_valid = 1'b1;
    if (expectOut) begin
      e.f = refFloat(v);
      e.lat = refLat(e.f);
      e.acc = edgeCnt + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_fixed = WIDTH'($urandom);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prevValid = 1'b0;
    end else begin
      if (out_valid && !prevValid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output got=%h want=none", out_float);
        end else begin
          e = sb.pop_front();
          check("value", out_float, e.f);
          check("latency", 32'(edgeCnt - e.acc), 32'(e.lat));
        end
      end
      prevValid = out_valid;
    end
  end

  task automatic waitValid();
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] specials [6];

  initial begin
    specials[0] = 23'h000000;
    specials[1] = 23'h400000;
    specials[2] = 23'h000001;
    specials[3] = 23'h3FFFFF;
    specials[4] = 23'h7FFFFF;
    specials[5] = 23'h200000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_float", out_float, 32'h0);
    check("reset_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    send(23'h200000, 1'b1);
    send(23'h600000, 1'b1);
    send(23'h400000, 1'b1);
    send(23'h000001, 1'b1);
    send(23'h000000, 1'b1);
    drain();
    check("ref_one", refFloat(23'h200000), 32'h3F800000);
    check("ref_tiny", refFloat(23'h000001), 32'h35000000);

    readyMode = 0;
    send(23'h100000, 1'b1);
    waitValid();
    for (int i = 0; i < 5; i++) begin
      in_fixed = WIDTH'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("hold_float", out_float, 32'h3F000000);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    readyMode = 1;
    @(posedge clk);
    #1;
    check("post_ready", 32'(in_ready), 32'd1);
    check("post_valid", 32'(out_valid), 32'd0);

    send(23'h000001, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    repeat (30) @(posedge clk);
    #1;
    check("abort_quiet", 32'(out_valid), 32'd0);
    send(23'h200000, 1'b1);
    drain();

    readyMode = 2;
    for (int i = 0; i < 60; i++) begin
      if (i % 5 == 0) send(specials[(i / 5) % 6], 1'b1);
      else send(WIDTH'($urandom), 1'b1);
    end
    drain();
    readyMode = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
